// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin arbitration path: default sizes and
// the one-hot / index / thermometer helpers used by arbiter and consumer alike.
package rr_arb_pkg;

  localparam int unsigned NDefault           = 4;
  localparam int unsigned StarveLimitDefault = 4;

  // Helpers work on a fixed maximum width; callers zero-extend and truncate.
  localparam int unsigned MaxN    = 32;
  localparam int unsigned MaxIdxW = 5;

  typedef logic [MaxN-1:0]    vec_t;
  typedef logic [MaxIdxW-1:0] idx_t;

  // Output register action chosen each cycle.
  typedef enum logic [1:0] {
    ActHold,
    ActLoad,
    ActDrain
  } out_act_e;

  function automatic logic is_onehot(input vec_t v);
    return (v != '0) && ((v & (v - vec_t'(1))) == '0);
  endfunction

  // Priority-free OR-encode; only meaningful for one-hot input.
  function automatic idx_t onehot_to_idx(input vec_t v);
    idx_t idx;
    idx = '0;
    for (int i = 0; i < MaxN; i++) begin
      if (v[i]) idx |= idx_t'(i);
    end
    return idx;
  endfunction

  function automatic vec_t thermo_above(input idx_t idx);
    vec_t m;
    for (int i = 0; i < MaxN; i++) begin
      m[i] = (i > int'(idx));
    end
    return m;
  endfunction

endpackage

// File: rtl/rr_wait_counter.sv
// Per-requester saturating wait counter with synchronous clear, hold, and a
// registered flag that asserts once the count reaches Limit.
module rr_wait_counter #(
  parameter int unsigned CntW  = 8,
  parameter int unsigned Limit = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic hold_i,
  output logic flag_o
);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            flag_q, flag_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (!hold_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
    // Flag follows the updated count so it lines up with the new value.
    flag_d = (32'(cnt_d) >= Limit);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

  assign flag_o = flag_q;

endmodule

// File: rtl/rr_grant_decoder.sv
// Consumer side of the round-robin arbiter: validates the grant, registers its
// index downstream, feeds back the priority mask and flags starving requesters.
module rr_grant_decoder
  import rr_arb_pkg::*;
#(
  parameter int unsigned N            = NDefault,
  parameter int unsigned IDX_W        = $clog2(N),
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned STARVE_LIMIT = StarveLimitDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     gnt,
  output logic [N-1:0]     mask_req,
  output logic             arb_hold,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  input  logic             out_ready,
  output logic             gnt_err,
  output logic [N-1:0]     starve
);

  logic [N-1:0]     mask_q, mask_d;
  logic             out_valid_q, out_valid_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic             gnt_err_q, gnt_err_d;

  logic     gnt_ok;
  logic     accept;
  out_act_e act;

  assign arb_hold = out_valid_q & ~out_ready;
  assign gnt_ok   = is_onehot(vec_t'(gnt)) & (|(gnt & req)) & ~arb_hold;
  assign accept   = gnt_ok;

  always_comb begin
    act       = ActHold;
    gnt_err_d = (|gnt) & ~gnt_ok;
    if (accept) begin
      act = ActLoad;
    end else if (out_valid_q && out_ready) begin
      // Downstream took the current index; nothing replaces it.
      act = ActDrain;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    mask_d      = mask_q;
    unique case (act)
      ActLoad: begin
        out_valid_d = 1'b1;
        out_idx_d   = IDX_W'(onehot_to_idx(vec_t'(gnt)));
        mask_d      = N'(thermo_above(onehot_to_idx(vec_t'(gnt))));
      end
      ActDrain: out_valid_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q      <= '1;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      gnt_err_q   <= 1'b0;
    end else begin
      mask_q      <= mask_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      gnt_err_q   <= gnt_err_d;
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_wait
    rr_wait_counter #(
      .CntW  (CNT_W),
      .Limit (STARVE_LIMIT)
    ) u_wait_counter (
      .clk_i  (clk),
      .rst_i  (rst),
      .clr_i  (~req[gi] | (accept & gnt[gi])),
      .hold_i (arb_hold),
      .flag_o (starve[gi])
    );
  end

  assign mask_req  = mask_q;
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign gnt_err   = gnt_err_q;

endmodule

// File: tb/tb_rr_grant_decoder.sv
// Directed bench for rr_grant_decoder: a behavioural model checked every cycle
// plus literal expectations at the key points of each scenario.
module tb_rr_grant_decoder;

  localparam int N = 4;
  localparam int IDX_W = 2;
  localparam int CNT_MAX = 255;
  localparam int LIMIT = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req, gnt;
  logic [N-1:0]     mask_req;
  logic             arb_hold, out_valid, out_ready, gnt_err;
  logic [IDX_W-1:0] out_idx;
  logic [N-1:0]     starve;

  int tests = 0;
  int fails = 0;

  rr_grant_decoder #(
    .N            (N),
    .IDX_W        (IDX_W),
    .CNT_W        (8),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .mask_req  (mask_req),
    .arb_hold  (arb_hold),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .out_ready (out_ready),
    .gnt_err   (gnt_err),
    .starve    (starve)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model.
  bit          m_init = 0;
  bit          m_valid;
  int          m_idx;
  logic [N-1:0] m_mask;
  bit          m_err;
  int          m_cnt[N];
  logic [N-1:0] m_starve;

  always @(posedge clk) begin
    bit hold, ok;
    int k;
    if (rst) begin
      m_init = 1;
      m_valid = 0;
      m_idx = 0;
      m_mask = '1;
      m_err = 0;
      m_starve = '0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else begin
      hold = m_valid && !out_ready;
      k = -1;
      for (int i = 0; i < N; i++) if (gnt[i]) k = i;
      ok = ($countones(gnt) == 1) && ((gnt & req) != 0) && !hold;
      m_err = (gnt != 0) && !ok;
      for (int i = 0; i < N; i++) begin
        if (!req[i] || (ok && k == i)) m_cnt[i] = 0;
        else if (!hold && m_cnt[i] < CNT_MAX) m_cnt[i] = m_cnt[i] + 1;
        m_starve[i] = (m_cnt[i] >= LIMIT);
      end
      if (ok) begin
        m_valid = 1;
        m_idx = k;
        for (int i = 0; i < N; i++) m_mask[i] = (i > k);
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      check("out_valid", 32'(out_valid), 32'(m_valid));
      check("out_idx", 32'(out_idx), 32'(m_idx));
      check("mask_req", 32'(mask_req), 32'(m_mask));
      check("gnt_err", 32'(gnt_err), 32'(m_err));
      check("starve", 32'(starve), 32'(m_starve));
      check("arb_hold", 32'(arb_hold), 32'(m_valid && !out_ready));
    end
  end

  // Apply inputs for one cycle; returns 1 time unit after the consuming edge.
  task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] g, input logic rdy);
    req = r;
    gnt = g;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    gnt = '0;
    out_ready = 1'b1;
    @(negedge clk);
    cyc(4'b0000, 4'b0000, 1'b1);
    cyc(4'b0000, 4'b0000, 1'b1);
    check("rst_mask", 32'(mask_req), 32'h0000_000f);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_err", 32'(gnt_err), 32'h0);
    check("rst_starve", 32'(starve), 32'h0);
    rst = 1'b0;

    // Sequential grants.
    cyc(4'b1111, 4'b0001, 1'b1);
    check("seq0_idx", 32'(out_idx), 32'd0);
    check("seq0_mask", 32'(mask_req), 32'b1110);
    cyc(4'b1111, 4'b0010, 1'b1);
    check("seq1_idx", 32'(out_idx), 32'd1);
    check("seq1_mask", 32'(mask_req), 32'b1100);
    cyc(4'b1111, 4'b0100, 1'b1);
    check("seq2_idx", 32'(out_idx), 32'd2);
    check("seq2_mask", 32'(mask_req), 32'b1000);
    cyc(4'b1111, 4'b1000, 1'b1);
    check("seq3_idx", 32'(out_idx), 32'd3);
    check("seq3_mask", 32'(mask_req), 32'b0000);
    check("seq3_valid", 32'(out_valid), 32'd1);
    cyc(4'b0000, 4'b0000, 1'b1);
    check("drain_valid", 32'(out_valid), 32'd0);

    // Back-pressure.
    cyc(4'b1111, 4'b0100, 1'b1);
    cyc(4'b1111, 4'b0000, 1'b0);
    check("bp_hold", 32'(arb_hold), 32'd1);
    check("bp_idx", 32'(out_idx), 32'd2);
    check("bp_mask", 32'(mask_req), 32'b1000);
    cyc(4'b1111, 4'b0001, 1'b0);
    check("bp_err", 32'(gnt_err), 32'd1);
    check("bp_idx2", 32'(out_idx), 32'd2);
    cyc(4'b1111, 4'b0000, 1'b0);
    check("bp_err_clr", 32'(gnt_err), 32'd0);
    cyc(4'b1111, 4'b0000, 1'b1);
    check("bp_drain", 32'(out_valid), 32'd0);

    // Protocol errors.
    cyc(4'b0110, 4'b0110, 1'b1);
    check("multi_err", 32'(gnt_err), 32'd1);
    check("multi_valid", 32'(out_valid), 32'd0);
    cyc(4'b0010, 4'b0001, 1'b1);
    check("nonreq_err", 32'(gnt_err), 32'd1);
    check("nonreq_mask", 32'(mask_req), 32'b1000);
    cyc(4'b0000, 4'b0000, 1'b1);
    check("err_pulse", 32'(gnt_err), 32'd0);

    // Starvation of requester 3.
    cyc(4'b1001, 4'b0001, 1'b1);
    cyc(4'b1001, 4'b0001, 1'b1);
    cyc(4'b1001, 4'b0001, 1'b1);
    check("starve_pre", 32'(starve), 32'b0000);
    cyc(4'b1001, 4'b0001, 1'b1);
    check("starve_set", 32'(starve), 32'b1000);
    cyc(4'b1001, 4'b1000, 1'b1);
    check("starve_clr", 32'(starve), 32'b0000);
    check("starve_idx", 32'(out_idx), 32'd3);

    // Counter saturation: requester 3 waits far longer than the counter range.
    for (int i = 0; i < 270; i++) cyc(4'b1000, 4'b0000, 1'b1);
    check("sat_starve", 32'(starve), 32'b1000);

    // Reset in the middle of a stall.
    cyc(4'b1111, 4'b0100, 1'b1);
    cyc(4'b1111, 4'b0000, 1'b0);
    cyc(4'b1111, 4'b0000, 1'b0);
    rst = 1'b1;
    cyc(4'b1111, 4'b0000, 1'b0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_hold", 32'(arb_hold), 32'd0);
    check("mid_rst_mask", 32'(mask_req), 32'b1111);
    check("mid_rst_idx", 32'(out_idx), 32'd0);
    rst = 1'b0;

    // Mixed traffic checked against the model.
    for (int i = 0; i < 300; i++) begin
      logic [N-1:0] r, g;
      r = N'($urandom);
      case ($urandom_range(0, 3))
        0: g = '0;
        1: g = N'($urandom);
        default: g = N'(1 << $urandom_range(0, N - 1));
      endcase
      cyc(r, g, 1'($urandom_range(0, 3) != 0));
    end

    cyc(4'b0000, 4'b0000, 1'b1);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rr_grant_decoder.md
Name: rr_grant_decoder

Overview:
- Consumer end of the round-robin arbitration interface.
- Takes the one-hot grant from the arbiter and checks it against the live request vector. Encodes it to a binary index and forwards it downstream through a registered valid/ready handshake.
- Returns the next-cycle thermometer priority mask to the arbiter's masked-request path.
- Back-pressures the arbiter when downstream stalls, and tracks per-requester wait time to flag starvation.

Parameters:
- N, 4, number of requesters (>=2).
- IDX_W, $clog2(N), width of encoded grant index.
- CNT_W, 8, width of each per-requester wait counter.
- STARVE_LIMIT, 4, accepted-cycle wait count at which starve[i] asserts.

Ports:
- clk  input  1  clock, all state updates on posedge.
- rst  input  1  reset, synchronous, active-high.
- req  input  N  live request vector, same vector the arbiter sees.
- gnt  input  N  grant from arbiter, one-hot or zero.
- mask_req  output  N  thermometer priority mask fed back to the arbiter for the next arbitration.
- arb_hold  output  1  arbiter must freeze (gnt=0) this cycle.
- out_valid  output  1  registered grant available downstream.
- out_idx  output  IDX_W  binary index of the forwarded grant.
- out_ready  input  1  downstream accepts out_idx when out_valid & out_ready.
- gnt_err  output  1  one-cycle registered pulse: protocol violation on gnt.
- starve  output  N  per-requester starvation flag.

Behaviour:
- Reset (rst=1 at posedge) values: mask_req={N{1}}; out_valid=0; out_idx=0; gnt_err=0; all wait counters=0; starve=0. rst overrides every other event, including a pending out_valid.
- arb_hold = out_valid & ~out_ready. This is combinational and is the only combinational output.
- gnt_ok = gnt is exactly one-hot & (gnt & req) != 0 & ~arb_hold.
- accept = gnt_ok.
- Violation = gnt != 0 & ~gnt_ok. Covers multi-hot, a grant to a non-requester, and any grant while arb_hold=1.
- On violation: gnt_err pulses high the next cycle. The grant is dropped; no mask, output or counter update.
- On accept of index k (1-cycle latency):
  - out_valid<=1, out_idx<=k.
  - mask_req<=bits strictly above k set, all others 0. Example: k=1 gives 4'b1100; k=N-1 gives all zeros, so the arbiter falls back to the unmasked path.
- Accept when out_valid=1 and out_ready=1: the new grant replaces the old one in the same cycle. No bubble; throughput is one grant per clock.
- Drain with no accept: out_valid=1 & out_ready=1 & no accept -> out_valid<=0.
- Stall: out_valid=1 & out_ready=0 -> out_valid and out_idx hold, and mask_req holds.
- gnt=0 with no violation: mask_req holds.
- Wait counters, per requester i, evaluated each cycle:
  - Cleared if req[i]=0, or if accept with k=i.
  - Held if arb_hold=1.
  - Otherwise incremented, saturating at 2^CNT_W-1.
- starve[i] is registered: 1 when counter_i >= STARVE_LIMIT, recomputed from the updated counter.
- req dropping mid-stall: no effect on a grant already in out_idx; that counter clears.
- No internal state machine beyond the output register. State is {out_valid, out_idx, mask_req, counters}.

Decomposition:
- Shared package rr_arb_pkg:
  - Function onehot_to_idx (priority-free OR-encode).
  - Function is_onehot.
  - Function thermo_above(idx) returning the thermometer mask.
  - Localparam defaults for N and STARVE_LIMIT, shared with thermometer_priority_mask and the arbiter top.
- One natural sub-module, rr_wait_counter: a single saturating counter with clear, hold and threshold flag, instantiated N times by generate.

Test Plan:
- Reset/idle: rst held 2 cycles, req=0, gnt=0 -> mask_req=4'b1111, out_valid=0, gnt_err=0, starve=4'b0000.
- Sequential grants: out_ready=1, req=4'b1111, gnt=0001,0010,0100,1000 on consecutive cycles -> each cycle later out_idx=0,1,2,3 with out_valid=1 throughout; mask_req=1110,1100,1000,0000.
- Back-pressure: after grant k=2, out_ready=0 for 3 cycles -> arb_hold=1, out_idx stays 2, mask_req stays 4'b1000. Injecting gnt=0001 during the stall -> gnt_err pulse, out_idx still 2. After out_ready=1, out_valid drops the next cycle if no new gnt.
- Protocol errors: gnt=4'b0110 with req=4'b0110 -> gnt_err one cycle, no output. gnt=4'b0001 with req=4'b0010 -> gnt_err, mask_req unchanged.
- Starvation: req=4'b1001, gnt=0001 held every cycle, out_ready=1 -> requester 3 counter reaches 4 and starve=4'b1000 on the 5th cycle. One gnt=1000 accept clears it the next cycle.
- Reset mid-operation: rst while out_valid=1, out_ready=0 and counters nonzero -> next cycle all outputs at reset values, arb_hold=0.
